// File: rtl/nios2_mul_seq_pkg.sv
// rtl/nios2_mul_seq_pkg.sv - shared op codes, FSM states and partial-product shifts
package nios2_mul_seq_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [1:0] OP_MULXSU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [5:0] PP_SHIFT0 = 6'd0;
  localparam logic [5:0] PP_SHIFT1 = 6'd16;
  localparam logic [5:0] PP_SHIFT2 = 6'd16;
  localparam logic [5:0] PP_SHIFT3 = 6'd32;

  // Shift applied to partial product idx (lo*lo, lo*hi, hi*lo, hi*hi).
  function automatic logic [5:0] pp_shift(input logic [1:0] idx);
    case (idx)
      2'd0:    return PP_SHIFT0;
      2'd1:    return PP_SHIFT1;
      2'd2:    return PP_SHIFT2;
      default: return PP_SHIFT3;
    endcase
  endfunction

endpackage

// File: rtl/nios2_mul_seq_cell.sv
// rtl/nios2_mul_seq_cell.sv - 16x16 unsigned multiplier with one output register
module nios2_mul_seq_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic [15:0] dataa,
  input  logic [15:0] datab,
  output logic [31:0] result
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= 32'd0;
    end else if (ena) begin
      result <= {16'd0, dataa} * {16'd0, datab};
    end
  end

endmodule

// File: rtl/nios2_mul_seq.sv
// rtl/nios2_mul_seq.sv - sequential 32x32 multiplier built from four 16x16 partials
module nios2_mul_seq
  import nios2_mul_seq_pkg::*;
#(
  parameter bit EARLY_MUL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [1:0]  op_q;
  logic        out_valid_q;
  logic [31:0] out_result_q;

  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] prod;
  logic        mul_ena;
  logic [2:0]  last_cnt;
  logic [63:0] acc_sum_d;
  logic [31:0] sub1_d;
  logic [31:0] sub2_d;
  logic [31:0] acc_hi_fix_d;
  logic [31:0] result_d;

  // Count bit 1 picks the src1 half, bit 0 the src2 half, giving lo*lo, lo*hi, hi*lo, hi*hi.
  assign mul_a   = cnt_q[1] ? src1_q[31:16] : src1_q[15:0];
  assign mul_b   = cnt_q[0] ? src2_q[31:16] : src2_q[15:0];
  assign mul_ena = (state_q == ST_MUL);

  nios2_mul_seq_cell u_cell (
    .clk     (clk),
    .reset_n (reset_n),
    .ena     (mul_ena),
    .dataa   (mul_a),
    .datab   (mul_b),
    .result  (prod)
  );

  assign last_cnt = (EARLY_MUL && (op_q == OP_MUL)) ? 3'd3 : 3'd4;

  // Product register holds partial cnt-1; cnt 4 wraps to index 3.
  assign acc_sum_d = acc_q + ({32'd0, prod} << pp_shift(cnt_q[1:0] - 2'd1));

  assign sub1_d = ((op_q == OP_MULXSS || op_q == OP_MULXSU) && src1_q[31]) ? src2_q : 32'd0;
  assign sub2_d = ((op_q == OP_MULXSS) && src2_q[31]) ? src1_q : 32'd0;
  assign acc_hi_fix_d = acc_q[63:32] - sub1_d - sub2_d;
  assign result_d = (op_q == OP_MUL) ? acc_q[31:0] : acc_hi_fix_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      acc_q        <= 64'd0;
      src1_q       <= 32'd0;
      src2_q       <= 32'd0;
      op_q         <= 2'd0;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            src1_q  <= in_src1;
            src2_q  <= in_src2;
            op_q    <= in_op;
            acc_q   <= 64'd0;
            cnt_q   <= 3'd0;
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (cnt_q != 3'd0) begin
            acc_q <= acc_sum_d;
          end
          if (cnt_q == last_cnt) begin
            cnt_q   <= 3'd0;
            state_q <= ST_FIX;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_FIX: begin
          acc_q        <= {acc_hi_fix_d, acc_q[31:0]};
          out_result_q <= result_d;
          out_valid_q  <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule

// File: tb/tb_nios2_mul_seq.sv
// tb/tb_nios2_mul_seq.sv - self-checking bench for nios2_mul_seq
module tb_nios2_mul_seq;

  localparam bit EARLY = 1'b1;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int errors = 0;
  int checks = 0;

  nios2_mul_seq #(.EARLY_MUL(EARLY)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full 64-bit product from sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'b10 || op == 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b10) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int ref_lat(input logic [1:0] op);
    return (EARLY && op == 2'b00) ? 5 : 6;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_result(input logic [1:0] op, input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(ref_lat(op)));
    check({tag, "_res"}, 64'(out_result), 64'(exp));
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_drop"}, 64'(out_valid), 64'd0);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 2'($urandom); in_src1 = $urandom; in_src2 = $urandom;
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
    wait_result(op, ref_mul(op, a, b), tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    reset_n = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_src1 = 32'd0; in_src2 = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    do_op(2'b00, 32'h0001_0003, 32'h0002_0005, "mul_small");
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "xuu_max");
    do_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, "xss_neg1");
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "xsu_min");
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "xuu_min");
    check("const_xuu_max", 64'(ref_mul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);

    // Output backpressure with a new request waiting.
    in_valid = 1'b1; in_op = 2'b10; in_src1 = 32'h1234_5678; in_src2 = 32'h8765_4321; out_ready = 1'b0;
    @(posedge clk); #1;
    in_op = 2'b11; in_src1 = 32'hDEAD_BEEF; in_src2 = 32'h0BAD_F00D;
    wait_result(2'b10, ref_mul(2'b10, 32'h1234_5678, 32'h8765_4321), "bp");
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_result_hold", 64'(out_result), 64'(held));
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_xfer_valid", 64'(out_valid), 64'd0);
    check("bp_xfer_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("bp_next_accept", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_result(2'b11, ref_mul(2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D), "bp_next");

    // Flush mid-multiply, then flush against a request while idle.
    in_valid = 1'b1; in_op = 2'b10; in_src1 = 32'hF000_0001; in_src2 = 32'h9000_0003;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'd7; in_src2 = 32'd9;
    @(posedge clk); #1;
    check("flush_idle", 64'(in_ready), 64'd1);
    check("flush_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("flush_no_accept", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("flush_no_result", 64'(out_valid), 64'd0);
    end

    // Reset asserted while in FIX.
    do_op(2'b01, 32'hCAFE_0000, 32'h0000_BABE, "pre_rst");
    in_valid = 1'b1; in_op = 2'b01; in_src1 = 32'hFFFF_0000; in_src2 = 32'h1234_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("rst_fix_valid", 64'(out_valid), 64'd0);
    check("rst_fix_result", 64'(out_result), 64'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_fix_ready", 64'(in_ready), 64'd1);
    check("rst_fix_still_invalid", 64'(out_valid), 64'd0);
    do_op(2'b00, 32'd3, 32'd5, "post_rst_mul");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = pick();
      rb  = pick();
      do_op(rop, ra, rb, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
